// File: rtl/adc_spi_reader.sv
`default_nettype none
// ============================================================================
// Module      : adc_spi_reader
// Description : SPI master for an MCP3202-class dual-channel 12-bit ADC.
//               Converts channel 0 and channel 1 alternately while enabled and
//               holds the last result of each channel on p1data / p2data.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk     in   system clock
//   reset   in   synchronous reset, active low
//   enable  in   level; frames run back to back while high
//   miso    in   ADC serial data out
//   sclk    out  SPI clock, idles low (mode 0,0)
//   mosi    out  ADC serial data in
//   cs_n    out  ADC chip select, active low
//   p1data  out  last channel-0 result (12 bits)
//   p2data  out  last channel-1 result (12 bits)
//   p1valid out  one-cycle pulse when p1data updates
//   p2valid out  one-cycle pulse when p2data updates
//   busy    out  high while cs_n is low
// ============================================================================
module adc_spi_reader #(
  parameter int CLK_DIV = 24,
  parameter int CS_GAP  = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic [11:0] p1data,
  output logic [11:0] p2data,
  output logic        p1valid,
  output logic        p2valid,
  output logic        busy
);

  // One shared cycle counter serves both the SCLK phases and the CS gap.
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] c_div_last = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] c_gap_last = CNT_W'(CS_GAP - 1);
  localparam logic [4:0]       c_last_per = 5'd16;  // period 17, zero-based
  localparam logic [4:0]       c_null_per = 5'd4;   // period 5, zero-based

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [4:0]       per_q,   per_d;     // SCLK period index, 0..16
  logic             sclk_q,  sclk_d;
  logic             mosi_q,  mosi_d;
  logic             cs_n_q,  cs_n_d;
  logic             busy_q,  busy_d;
  logic             ch_q,    ch_d;      // channel being converted
  logic [11:0]      shreg_q, shreg_d;
  logic [11:0]      p1data_q, p1data_d;
  logic [11:0]      p2data_q, p2data_d;
  logic             p1valid_q, p1valid_d;
  logic             p2valid_q, p2valid_d;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      per_q     <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      ch_q      <= 1'b0;
      shreg_q   <= '0;
      p1data_q  <= '0;
      p2data_q  <= '0;
      p1valid_q <= 1'b0;
      p2valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      ch_q      <= ch_d;
      shreg_q   <= shreg_d;
      p1data_q  <= p1data_d;
      p2data_q  <= p2data_d;
      p1valid_q <= p1valid_d;
      p2valid_q <= p2valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    ch_d      = ch_q;
    shreg_d   = shreg_q;
    p1data_d  = p1data_q;
    p2data_d  = p2data_q;
    p1valid_d = 1'b0;
    p2valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = ST_SETUP;
          cs_n_d  = 1'b0;
          mosi_d  = 1'b1;   // start bit
        end
      end

      ST_SETUP: begin
        if (cnt_q == c_div_last) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          per_d   = '0;
          sclk_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (cnt_q == c_div_last) begin
          cnt_d = '0;
          if (sclk_q) begin
            // End of the high phase: sample miso and advance mosi together,
            // so mosi only ever moves on an sclk falling edge.
            sclk_d = 1'b0;
            if (per_q > c_null_per) begin
              shreg_d = {shreg_q[10:0], miso};
            end
            case (per_q)
              5'd0:    mosi_d = 1'b1;  // SGL
              5'd1:    mosi_d = ch_q;  // ODD selects the channel
              5'd2:    mosi_d = 1'b1;  // MSBF
              default: mosi_d = 1'b0;
            endcase
          end else if (per_q == c_last_per) begin
            state_d = ST_HOLD;
          end else begin
            sclk_d = 1'b1;
            per_d  = per_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt_q == c_div_last) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          if (ch_q) begin
            p2data_d  = shreg_q;
            p2valid_d = 1'b1;
          end else begin
            p1data_d  = shreg_q;
            p1valid_d = 1'b1;
          end
          ch_d = ~ch_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_q == c_gap_last) begin
          cnt_d = '0;
          if (enable) begin
            state_d = ST_SETUP;
            cs_n_d  = 1'b0;
            mosi_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        sclk_d  = 1'b0;
        cs_n_d  = 1'b1;
      end
    endcase

    // busy is registered alongside cs_n so the two can never disagree.
    busy_d = ~cs_n_d;
  end

  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;
  assign busy    = busy_q;
  assign p1data  = p1data_q;
  assign p2data  = p2data_q;
  assign p1valid = p1valid_q;
  assign p2valid = p2valid_q;

endmodule
`default_nettype wire

// File: doc/adc_spi_reader.md
Name: adc_spi_reader

Overview:
- SPI master for an MCP3202-class dual-channel 12-bit ADC.
- Continuously converts both player sensor channels and presents the results as 12-bit words for the single- and multi-player game logic.
- Channels alternate: channel 0 updates p1data, channel 1 updates p2data.
- Each output holds its last conversion until that channel is converted again.

Parameters:
- CLK_DIV, default 24: clk cycles per SCLK half-period; legal values are 2 or greater.
- CS_GAP, default 24: minimum clk cycles cs_n stays high between frames; legal values are 1 or greater.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  level; while high, frames run back to back.
- miso  in  1  ADC serial data out.
- sclk  out  1  SPI clock; idles low (mode 0,0).
- mosi  out  1  ADC serial data in.
- cs_n  out  1  ADC chip select, active low.
- p1data  out  12  last channel-0 result.
- p2data  out  12  last channel-1 result.
- p1valid  out  1  one-cycle pulse when p1data updates.
- p2valid  out  1  one-cycle pulse when p2data updates.
- busy  out  1  high while cs_n is low.

Behaviour:
- Reset is sampled at posedge clk while reset==0. Reset values:
  - cs_n=1, sclk=0, mosi=0, busy=0.
  - p1data=0, p2data=0, p1valid=0, p2valid=0.
  - Internal channel pointer=0, divider=0, state=IDLE.
- Reset has priority over everything. If asserted mid-frame, the frame is abandoned on that edge with no valid pulse.
- All outputs are registered.
- States:
  - IDLE -> SETUP when enable=1.
  - SETUP -> SHIFT after CLK_DIV cycles.
  - SHIFT -> HOLD after 17 SCLK periods.
  - HOLD -> GAP after CLK_DIV cycles.
  - GAP -> SETUP if enable=1 once CS_GAP cycles have elapsed, else GAP -> IDLE.
- SETUP:
  - cs_n=0 and mosi=1 (start bit) are driven on the entry edge.
  - sclk stays low for CLK_DIV cycles.
- SHIFT, 17 SCLK periods numbered 1..17:
  - Each period is sclk high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - mosi sequence for periods 1-4 is start=1, SGL=1, ODD=channel, MSBF=1; mosi=0 for periods 5-17.
  - mosi changes only on the edge that drives sclk low.
  - miso is sampled on the last clk cycle of each high phase.
  - The period-5 sample (null bit) is discarded.
  - Periods 6-17 shift in B11..B0, MSB first.
- HOLD: sclk=0 and cs_n=0 for CLK_DIV cycles.
- Completion:
  - On the edge leaving HOLD, cs_n is driven to 1.
  - On the same edge, the result loads p1data (channel 0) or p2data (channel 1) and the matching valid pulses high for exactly one cycle.
  - The channel pointer then toggles.
- Timing:
  - cs_n is low for exactly 36*CLK_DIV cycles.
  - cs_n is high for at least CS_GAP cycles between frames.
  - sclk is 0 whenever cs_n=1.
- If enable falls mid-frame, the current frame completes normally, including its valid pulse, and the block then enters IDLE after GAP.
- If enable rises during GAP, the next frame starts only after the full CS_GAP.
- busy equals ~cs_n.
- A channel's data register never changes except on its own valid pulse or on reset.

Test Plan:
All scenarios use CLK_DIV=4 and CS_GAP=8 with an MCP3202 behavioural model.
- Reset: hold reset=0 for 3 cycles with enable=1 -> cs_n=1, sclk=0, p1data=p2data=0, no valid pulses, busy=0.
- Channel-0 frame: release reset with model ch0=0xA5C -> mosi bits sampled on rising sclk 1-4 are 1,1,0,1; cs_n low for exactly 144 cycles; 17 sclk pulses; p1data=0xA5C with a single-cycle p1valid; p2data stays 0.
- Alternation: keep enable=1 with model ch1=0x3FF -> next frame ODD=1, p2data=0x3FF, p2valid pulses once, p1data holds 0xA5C; cs_n high exactly 8 cycles between frames.
- Null bit: model drives miso=1 on the null bit and 0x000 data -> p1data=0x000.
- Enable drop: deassert enable during sclk period 8 -> frame completes, its valid pulses, then cs_n stays high, busy=0, no further sclk edges.
- Mid-frame reset: assert reset during period 10 -> next edge gives cs_n=1, sclk=0, data=0, no valid pulse; after release with enable=1, the first frame uses channel 0 (ODD=0).
